// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types, constants and offset decode for the PC sequencer
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      HALT = 2'd3
   } seq_state_e;

   localparam int          BR_OFF_SHIFT   = 19;
   localparam int          JAL_OFF_SHIFT  = 11;
   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DEF_PC_STEP    = 32'd4;

   // The offset arrives left-aligned, so an arithmetic shift both sign-extends
   // and scales it to a byte offset; bit 0 is forced low as it is never encoded.
   function automatic logic [31:0] decode_offset(input logic [31:0] off, input logic is_jump);
      logic [31:0] d;
      if (is_jump)
         d = $unsigned($signed(off) >>> JAL_OFF_SHIFT);
      else
         d = $unsigned($signed(off) >>> BR_OFF_SHIFT);
      d[0] = 1'b0;
      return d;
   endfunction

endpackage

// File: rtl/cpu_target_calc.sv
// rtl/cpu_target_calc.sv - combinational redirect target computation
module cpu_target_calc
   import cpu_pkg::*;
(
   input  logic [31:0] redirect_pc,
   input  logic [31:0] offset,
   input  logic        redirect_is_jump,
   output logic [31:0] target,
   output logic        target_misaligned
);

   // Wrap-around past 2^32 is intentionally silent.
   assign target            = redirect_pc + decode_offset(offset, redirect_is_jump);
   assign target_misaligned = target[1];

endmodule

// File: rtl/cpu_pc_sequencer.sv
// rtl/cpu_pc_sequencer.sv - fetch PC sequencer with redirect, flush and misalignment halt
module cpu_pc_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] PC_STEP  = DEF_PC_STEP
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        imem_ready,
   output logic        imem_valid,
   output logic [31:0] pc,
   input  logic        redirect_valid,
   input  logic        redirect_is_jump,
   input  logic        redirect_taken,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] offset,
   output logic        flush,
   output logic [31:0] target,
   output logic        misaligned
);

   seq_state_e  state_q;
   logic [31:0] pc_q;
   logic [31:0] target_q;
   logic        flush_q;
   logic        misaligned_q;

   logic [31:0] calc_target;
   logic        calc_misaligned;
   logic        redirect_take;
   logic [31:0] pc_seq_d;

   cpu_target_calc u_target_calc (
      .redirect_pc       (redirect_pc),
      .offset            (offset),
      .redirect_is_jump  (redirect_is_jump),
      .target            (calc_target),
      .target_misaligned (calc_misaligned)
   );

   assign redirect_take = redirect_valid && (redirect_is_jump || redirect_taken);
   assign pc_seq_d      = pc_q + PC_STEP;

   // Request valid depends on state and stall only, never on imem_ready.
   always_comb begin
      imem_valid = 1'b0;
      case (state_q)
         RUN:     imem_valid = !stall;
         HOLD:    imem_valid = 1'b1;
         default: imem_valid = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         target_q     <= 32'h0;
         flush_q      <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         flush_q <= 1'b0;
         if (redirect_take && state_q != HALT) begin
            // A redirect retracts any pending request and beats the increment.
            flush_q  <= 1'b1;
            target_q <= calc_target;
            if (calc_misaligned) begin
               misaligned_q <= 1'b1;
               state_q      <= HALT;
            end else begin
               pc_q    <= calc_target;
               state_q <= RUN;
            end
         end else begin
            case (state_q)
               IDLE: state_q <= RUN;
               RUN: begin
                  if (imem_valid && imem_ready)
                     pc_q <= pc_seq_d;
                  else if (imem_valid)
                     state_q <= HOLD;
               end
               HOLD: begin
                  if (imem_ready) begin
                     pc_q    <= pc_seq_d;
                     state_q <= RUN;
                  end
               end
               default: state_q <= HALT;
            endcase
         end
      end
   end

   assign pc         = pc_q;
   assign target     = target_q;
   assign flush      = flush_q;
   assign misaligned = misaligned_q;

endmodule

// File: tb/tb_cpu_pc_sequencer.sv
// tb/tb_cpu_pc_sequencer.sv - scoreboard bench for the fetch PC sequencer
module tb_cpu_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        imem_ready;
   logic        imem_valid;
   logic [31:0] pc;
   logic        redirect_valid;
   logic        redirect_is_jump;
   logic        redirect_taken;
   logic [31:0] redirect_pc;
   logic [31:0] offset;
   logic        flush;
   logic [31:0] target;
   logic        misaligned;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] sb_q[$];

   cpu_pc_sequencer #(
      .RESET_PC (32'h0000_0100),
      .PC_STEP  (32'd4)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .stall            (stall),
      .imem_ready       (imem_ready),
      .imem_valid       (imem_valid),
      .pc               (pc),
      .redirect_valid   (redirect_valid),
      .redirect_is_jump (redirect_is_jump),
      .redirect_taken   (redirect_taken),
      .redirect_pc      (redirect_pc),
      .offset           (offset),
      .flush            (flush),
      .target           (target),
      .misaligned       (misaligned)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic redir(input logic jmp, input logic tkn, input logic [31:0] rpc, input logic [31:0] off);
      redirect_valid   = 1'b1;
      redirect_is_jump = jmp;
      redirect_taken   = tkn;
      redirect_pc      = rpc;
      offset           = off;
   endtask

   task automatic redir_off();
      redirect_valid   = 1'b0;
      redirect_is_jump = 1'b0;
      redirect_taken   = 1'b0;
      redirect_pc      = 32'h0;
      offset           = 32'h0;
   endtask

   // Each completed fetch handshake is compared against the next expected address.
   always @(negedge clk) begin
      if (rst_n && imem_valid && imem_ready) begin
         if (sb_q.size() == 0)
            chk("fetch_unexpected", pc, 32'hDEAD_BEEF);
         else
            chk("fetch_pc", pc, sb_q.pop_front());
      end
   end

   initial begin
      rst_n      = 1'b0;
      stall      = 1'b0;
      imem_ready = 1'b0;
      redir_off();
      repeat (3) cyc();
      chk("rst_pc", pc, 32'h100);
      chk("rst_valid", {31'b0, imem_valid}, 32'd0);
      chk("rst_flush", {31'b0, flush}, 32'd0);
      chk("rst_target", target, 32'h0);
      chk("rst_mis", {31'b0, misaligned}, 32'd0);

      imem_ready = 1'b1;
      rst_n      = 1'b1;
      cyc();
      chk("idle_valid", {31'b0, imem_valid}, 32'd1);
      chk("seq_pc0", pc, 32'h100);
      sb_q.push_back(32'h100);
      cyc();
      chk("seq_pc1", pc, 32'h104);
      sb_q.push_back(32'h104);
      cyc();
      chk("seq_pc2", pc, 32'h108);
      chk("seq_flush", {31'b0, flush}, 32'd0);
      chk("seq_mis", {31'b0, misaligned}, 32'd0);
      sb_q.push_back(32'h108);
      redir(1'b0, 1'b1, 32'h100, 32'h0040_0000);
      cyc();
      chk("br_pc", pc, 32'h108);
      chk("br_target", target, 32'h108);
      chk("br_flush", {31'b0, flush}, 32'd1);
      sb_q.push_back(32'h108);
      redir_off();
      cyc();
      chk("br_flush_fall", {31'b0, flush}, 32'd0);
      chk("br_pc_next", pc, 32'h10C);
      sb_q.push_back(32'h10C);
      redir(1'b0, 1'b0, 32'h100, 32'h0040_0000);
      cyc();
      chk("nt_pc", pc, 32'h110);
      chk("nt_flush", {31'b0, flush}, 32'd0);
      chk("nt_target", target, 32'h108);
      sb_q.push_back(32'h110);
      redir(1'b1, 1'b0, 32'h40, 32'h0010_0000);
      cyc();
      chk("jal_fwd_pc", pc, 32'h240);
      chk("jal_fwd_target", target, 32'h240);
      chk("jal_fwd_flush", {31'b0, flush}, 32'd1);
      sb_q.push_back(32'h240);
      redir(1'b1, 1'b0, 32'h40, 32'hFFFF_E000);
      cyc();
      chk("jal_back_pc", pc, 32'h3C);
      chk("jal_back_target", target, 32'h3C);
      chk("b2b_flush", {31'b0, flush}, 32'd1);
      sb_q.push_back(32'h3C);
      redir(1'b1, 1'b1, 32'h200, 32'h0);
      cyc();
      chk("to200_pc", pc, 32'h200);
      redir_off();
      imem_ready = 1'b0;
      cyc();
      chk("hold0_valid", {31'b0, imem_valid}, 32'd1);
      chk("hold0_pc", pc, 32'h200);
      chk("hold0_flush", {31'b0, flush}, 32'd0);
      stall = 1'b1;
      cyc();
      chk("hold1_valid", {31'b0, imem_valid}, 32'd1);
      chk("hold1_pc", pc, 32'h200);
      stall = 1'b0;
      cyc();
      chk("hold2_valid", {31'b0, imem_valid}, 32'd1);
      chk("hold2_pc", pc, 32'h200);
      imem_ready = 1'b1;
      sb_q.push_back(32'h200);
      cyc();
      chk("hold_rel_pc", pc, 32'h204);
      stall = 1'b1;
      cyc();
      chk("stall_valid", {31'b0, imem_valid}, 32'd0);
      chk("stall_pc", pc, 32'h204);
      stall = 1'b0;
      sb_q.push_back(32'h204);
      redir(1'b0, 1'b1, 32'h100, 32'hFFF0_0000);
      cyc();
      chk("mis_target", target, 32'hFE);
      chk("mis_flag", {31'b0, misaligned}, 32'd1);
      chk("mis_flush", {31'b0, flush}, 32'd1);
      chk("mis_pc", pc, 32'h204);
      chk("mis_valid", {31'b0, imem_valid}, 32'd0);
      redir_off();
      cyc();
      chk("halt_flush", {31'b0, flush}, 32'd0);
      chk("halt_valid", {31'b0, imem_valid}, 32'd0);
      redir(1'b1, 1'b0, 32'h40, 32'h0010_0000);
      cyc();
      chk("halt_ign_pc", pc, 32'h204);
      chk("halt_ign_target", target, 32'hFE);
      chk("halt_ign_flush", {31'b0, flush}, 32'd0);
      chk("halt_ign_mis", {31'b0, misaligned}, 32'd1);
      redir_off();
      rst_n = 1'b0;
      cyc();
      chk("halt_rst_mis", {31'b0, misaligned}, 32'd0);
      chk("halt_rst_pc", pc, 32'h100);

      imem_ready = 1'b0;
      rst_n      = 1'b1;
      cyc();
      chk("r2_valid", {31'b0, imem_valid}, 32'd1);
      cyc();
      chk("r2_hold_valid", {31'b0, imem_valid}, 32'd1);
      chk("r2_hold_pc", pc, 32'h100);
      rst_n = 1'b0;
      redir(1'b0, 1'b1, 32'h100, 32'h0040_0000);
      cyc();
      chk("rsthold_pc", pc, 32'h100);
      chk("rsthold_valid", {31'b0, imem_valid}, 32'd0);
      chk("rsthold_flush", {31'b0, flush}, 32'd0);
      chk("rsthold_target", target, 32'h0);
      chk("rsthold_mis", {31'b0, misaligned}, 32'd0);
      redir_off();
      @(negedge clk);
      #1;
      chk("sb_left", sb_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_pc_sequencer.md
# cpu_pc_sequencer

Program-counter sequencer that consumes the left-aligned control-transfer offset produced by the CPU's branch/store/jump offset generator and drives the instruction-memory fetch address. It advances the PC sequentially under a valid/ready fetch handshake. On a taken branch or a jump resolved in execute, it redirects the PC to `redirect_pc + offset` and pulses a one-cycle flush. A misaligned target halts fetch until reset.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `PC_STEP`, default 4: sequential increment in bytes.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset is synchronous and active-low.
- `stall`  in  1  downstream pipeline full; no new fetch is issued.
- `imem_ready`  in  1  instruction memory accepts the address this cycle.
- `imem_valid`  out  1  fetch request valid; `pc` is the fetch address.
- `pc`  out  32  current fetch address.
- `redirect_valid`  in  1  execute has resolved a control instruction this cycle.
- `redirect_is_jump`  in  1  1 = jump-format offset; 0 = branch-format offset.
- `redirect_taken`  in  1  branch condition result; ignored when `redirect_is_jump`=1.
- `redirect_pc`  in  32  PC of the resolved control instruction.
- `offset`  in  32  left-aligned immediate:
  - branch: imm[12:1] in bits [31:20], bits [19:0] = 0.
  - jump: imm[20:1] in bits [31:12], bits [11:0] = 0.
- `flush`  out  1  one-cycle pulse that kills younger in-flight instructions.
- `target`  out  32  last computed redirect target, registered.
- `misaligned`  out  1  sticky error: a taken target had bit 1 set.

## Operation
- Byte offset decode:
  - branch: `$signed(offset) >>> 19`.
  - jump: `$signed(offset) >>> 11`.
  - Result is 32-bit signed with bit 0 always 0.
- Target = `redirect_pc + decoded_offset`, modulo 2^32; wrap-around is silent.
- Redirect is taken when `redirect_valid && (redirect_is_jump || redirect_taken)`. A not-taken redirect has no effect.
- States:
  - IDLE: one cycle after reset, then RUN.
  - RUN: `imem_valid = !stall`.
  - HOLD: request pending; `imem_valid = 1`, `pc` held.
  - HALT: `imem_valid = 0`; exits only via reset.
- RUN transitions:
  - `imem_valid && imem_ready`: `pc += PC_STEP`, stay in RUN.
  - `imem_valid && !imem_ready`: go to HOLD.
- HOLD transitions: `imem_ready`=1 → `pc += PC_STEP`, go to RUN. `stall` is ignored while a request is pending.
- Taken redirect, any state except HALT, target[1]=0:
  - `pc <= target`, `target` register updated, `flush <= 1`, next state RUN.
  - Overrides the sequential increment, stall and a pending HOLD request. Memory treats the changed address as a new request; this is the only permitted retraction.
- Taken redirect with target[1]=1:
  - `flush <= 1`, `misaligned <= 1`, `target` register updated, `pc` unchanged, next state HALT.
- Redirects in HALT are ignored.
- Back-to-back taken redirects are each honoured in cycle order; the later one wins.
- Reset mid-operation, i.e. `rst_n`=0 at any edge, including HOLD or during a redirect:
  - `pc`=RESET_PC, `imem_valid`=0, `flush`=0, `target`=0, `misaligned`=0, state IDLE.

## Timing
- Redirect-to-PC latency is 1 cycle: a redirect sampled at edge N gives the new `pc` and `flush`=1 after edge N. `flush` falls after edge N+1 unless another taken redirect was sampled at N+1.
- Target decode and add are combinational from the redirect inputs; only `pc`, `target`, `flush`, `misaligned` and the state are registered.
- `imem_valid` is combinational from state and `stall` only. It has no combinational path from `imem_ready`.
- While `imem_valid && !imem_ready`, `pc` is stable, except on a taken redirect.
- First fetch after reset release: `imem_valid` can rise no earlier than the cycle after IDLE.

## Structure
- Shared package `cpu_pkg` holds:
  - state enum: IDLE, RUN, HOLD, HALT;
  - `BR_OFF_SHIFT`=19, `JAL_OFF_SHIFT`=11;
  - default `RESET_PC` and `PC_STEP`.
- One combinational sub-module, `cpu_target_calc`. Inputs: `redirect_pc`, `offset`, `redirect_is_jump`. Outputs: `target`, `target_misaligned`.
- The sequencer FSM and registers live in the top module.

## Test plan
- Reset with RESET_PC=32'h100 and `imem_ready`=1 held:
  - after release, `pc` = 0x100, 0x104, 0x108 on successive valid cycles;
  - `flush`=0, `misaligned`=0.
- Taken branch: `redirect_pc`=0x100, `offset`=32'h0040_0000, `is_jump`=0, `taken`=1 → next cycle `pc`=0x108, `target`=0x108, `flush`=1 for exactly 1 cycle. The same inputs with `taken`=0 leave the `pc` sequence unchanged.
- Jumps with `redirect_pc`=0x40:
  - `offset`=32'h0010_0000 → `pc`=0x240;
  - `offset`=32'hFFFF_E000 → `pc`=0x3C.
- Handshake: `imem_ready`=0 for 3 cycles at `pc`=0x200 → `imem_valid`=1 and `pc`=0x200 held throughout. Asserting `stall`=1 in the middle cycle changes nothing. `ready`=1 → `pc`=0x204.
- Misaligned branch: `redirect_pc`=0x100, `offset`=32'hFFF0_0000 → `target`=0xFE, `misaligned`=1, `flush`=1 once, `imem_valid`=0 thereafter. A later redirect is ignored; only `rst_n`=0 clears the halt.
- Reset asserted in HOLD, in the same cycle as a taken redirect → all outputs at reset values next cycle and no `flush` pulse.
